load_extend_unit: RTL
=====================

# load_extend_unit

Parametrised, registered load-data formatter for the datapath's memory stage. Takes a raw memory word, byte offset, access size and signedness; extracts the addressed byte/half/word field; sign- or zero-extends it to the full datapath width; presents it on a valid/ready output. Supersedes the fixed 8-to-32 extenders. Loads that straddle a word boundary are assembled from two consecutive memory beats.

## Interface
- DATA_W, 32: datapath and memory word width; multiple of 8, power of two, 16..128.
- BYTES, DATA_W/8: derived; bytes per word.
- OFF_W, $clog2(BYTES): derived; byte-offset width.
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request beat or second (high) memory beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  memory word.
- in_offset  in  OFF_W  byte offset of the field within in_data; sampled on first beat only.
- in_size  in  2  log2 of field bytes: 0 byte, 1 half, 2 word32, 3 word64; sampled on first beat only.
- in_signed  in  1  1 = sign-extend, 0 = zero-extend; sampled on first beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_W  extended result.
- out_err  out  1  result is an error (illegal size, or straddle with feature compiled out); out_data = 0.

## Operation
- States: IDLE, HI_WAIT, HOLD.
- Field bytes N = 1 << in_size. Illegal when N > BYTES. Straddle when in_offset + N > BYTES.
- IDLE, beat accepted: illegal -> HOLD with out_err=1, out_data=0; straddle -> store in_data as lo word plus offset/size/signed, go HI_WAIT; otherwise -> HOLD with formatted result.
- HI_WAIT: next accepted beat is the high word; only in_data used; form {hi, lo} >> (8*offset), take low N bytes, extend -> HOLD.
- HOLD: out_valid=1; outputs stable until handshake. On handshake with no new beat -> IDLE; with a simultaneous new first beat -> evaluated as from IDLE (back-to-back).
- Extension: bits [8N-1:0] = field; upper bits = field[8N-1] if signed else 0. N = BYTES: no extension, in_signed ignored.
- in_ready = !Rst && (state != HOLD || out_ready).

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_err 0, stored lo word/fields 0; in_ready 0 while Rst high.
- Aligned latency: first beat accepted at cycle T -> out_valid at T+1.
- Straddle latency: high beat accepted at M -> out_valid at M+1; no bound on gap between beats.
- Throughput: one aligned result per cycle when out_ready is held high.
- Rst during HI_WAIT or HOLD: pending lo word and result discarded, no output produced.
- out_ready low in HOLD: out_data/out_err held, in_ready low.

## Configuration
- LOAD_EXT_MISALIGN_EN defined: straddle assembly as above; HI_WAIT reachable.
- Undefined: HI_WAIT and lo-word storage removed; straddle request -> HOLD next cycle with out_err=1, out_data=0; never consumes a second beat.

## Structure
- Package load_ext_pkg: size encoding constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3), state enum, helper function for field byte count.
- Sub-module field_extend: combinational; inputs 2*DATA_W window, offset, size, signed; output extended DATA_W result. Instantiated once; top holds the FSM and registers.

## Test plan
- DATA_W=32, in_data=0x12345680, offset=0, size=0, signed=1 -> out_data=0xFFFFFF80 one cycle later; signed=0 -> 0x00000080.
- offset=2, size=1, signed=1, in_data=0x8001_0000 -> 0xFFFF8001; signed=0 -> 0x00008001.
- With LOAD_EXT_MISALIGN_EN: offset=3, size=1, lo=0xAA000000, hi=0x000000FF, signed=1 -> 0xFFFFFFAA one cycle after hi beat; without macro -> out_err=1, out_data=0, hi beat not consumed.
- out_ready held low 5 cycles in HOLD -> out_data stable, in_ready=0; 8 back-to-back aligned beats with out_ready=1 -> 8 results in 8 consecutive cycles.
- Rst asserted in HI_WAIT -> outputs 0 immediately; next aligned request formatted correctly, stale lo word unused.
- size=3 with DATA_W=32 -> out_err=1, out_data=0; DATA_W=64, size=3 -> full word passed unchanged.

Source files
------------

// File: rtl/load_extend_unit_pkg.sv
// Shared encodings for the load-extend unit: access-size codes, FSM states,
// and the size-to-byte-count helper.
package load_ext_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HI_WAIT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    function automatic logic [31:0] field_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/load_extend_unit_if.sv
// Request/response bundle of the load-extend unit: the slave modport is the
// formatter, the master modport is the memory stage driving it.
interface load_extend_unit_if #(
    parameter int DATA_W = 32
) ();
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_offset;
    logic [1:0]        in_size;
    logic              in_signed;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, in_offset, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/load_extend_unit_field_extend.sv
// Combinational field extractor: shifts a two-word window down by the byte
// offset, keeps the low N bytes and sign- or zero-extends them to DATA_W.
module field_extend
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0]          window,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [1:0]                   size,
    input  logic                         is_signed,
    output logic [DATA_W-1:0]            result
);
    localparam int IDX_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   low_word;
    logic [DATA_W-1:0]   ext_mask;
    logic [31:0]         nbits;
    logic [IDX_W-1:0]    msb_idx;
    logic                sign_bit;

    always_comb begin
        shifted  = window >> {offset, 3'b000};
        low_word = shifted[DATA_W-1:0];
        nbits    = field_bytes(size) << 3;
        msb_idx  = IDX_W'(nbits - 32'd1);
        // A full-width (or wider) field leaves the mask empty, so no extension.
        ext_mask = {DATA_W{1'b1}} << nbits;
        sign_bit = is_signed && (nbits < 32'(DATA_W)) && low_word[msb_idx];
        result   = sign_bit ? (low_word | ext_mask) : (low_word & ~ext_mask);
    end

endmodule

// File: rtl/load_extend_unit.sv
// Registered load-data formatter. Define LOAD_EXT_MISALIGN_EN to assemble
// word-straddling loads from two beats; otherwise straddles return an error.
module load_extend_unit
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_extend_unit_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_err_q, out_err_d;

    logic                accept;
    logic                illegal;
    logic                straddle;
    logic [31:0]         nbytes;
    logic [31:0]         span;

    logic [2*DATA_W-1:0] fx_window;
    logic [OFF_W-1:0]    fx_offset;
    logic [1:0]          fx_size;
    logic                fx_signed;
    logic [DATA_W-1:0]   fx_result;

`ifdef LOAD_EXT_MISALIGN_EN
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
`endif

    assign bus.in_ready  = !rst && (state_q != ST_HOLD || bus.out_ready);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign nbytes   = field_bytes(bus.in_size);
    assign span     = 32'(bus.in_offset) + nbytes;
    assign illegal  = nbytes > 32'(BYTES);
    assign straddle = span > 32'(BYTES);

    always_comb begin
        fx_window = {{DATA_W{1'b0}}, bus.in_data};
        fx_offset = bus.in_offset;
        fx_size   = bus.in_size;
        fx_signed = bus.in_signed;
`ifdef LOAD_EXT_MISALIGN_EN
        // The high beat carries no attributes; use those captured with the low beat.
        if (state_q == ST_HI_WAIT) begin
            fx_window = {bus.in_data, lo_q};
            fx_offset = off_q;
            fx_size   = size_q;
            fx_signed = sgn_q;
        end
`endif
    end

    field_extend #(.DATA_W(DATA_W)) u_field_extend (
        .window    (fx_window),
        .offset    (fx_offset),
        .size      (fx_size),
        .is_signed (fx_signed),
        .result    (fx_result)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
`ifdef LOAD_EXT_MISALIGN_EN
        lo_d       = lo_q;
        off_d      = off_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
`endif
        case (state_q)
            ST_HI_WAIT: begin
`ifdef LOAD_EXT_MISALIGN_EN
                if (accept) begin
                    state_d    = ST_HOLD;
                    out_data_d = fx_result;
                    out_err_d  = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                // IDLE, or HOLD being drained: a beat here is always a first beat.
                if (accept) begin
                    state_d    = ST_HOLD;
                    out_data_d = fx_result;
                    out_err_d  = 1'b0;
                    if (illegal) begin
                        out_data_d = '0;
                        out_err_d  = 1'b1;
                    end else if (straddle) begin
`ifdef LOAD_EXT_MISALIGN_EN
                        state_d = ST_HI_WAIT;
                        lo_d    = bus.in_data;
                        off_d   = bus.in_offset;
                        size_d  = bus.in_size;
                        sgn_d   = bus.in_signed;
`else
                        out_data_d = '0;
                        out_err_d  = 1'b1;
`endif
                    end
                end else if (state_q == ST_HOLD && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
`ifdef LOAD_EXT_MISALIGN_EN
            lo_q       <= '0;
            off_q      <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
`ifdef LOAD_EXT_MISALIGN_EN
            lo_q       <= lo_d;
            off_q      <= off_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
`endif
        end
    end

endmodule
